ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX register.
- Consumes ID/EX outputs: instruction fields, PC+4, sign-extended immediate, two register operands, and WB/MEM/EX control.
- Performs operand forwarding, ALU operation, destination select and branch-target compute, then registers the results for the MEM stage.
- Contains an iterative 32-step multiplier. It stalls the upstream stage with ex_stall while busy.

Parameters:
- DATA_W, 32, datapath width; the multiplier step count equals DATA_W.
- REG_W, 5, register-index width.

Ports:
- clock  in  1  rising-edge clock
- startin  in  1  synchronous active-high reset
- id_ex_instr  in  15  [14:10]=rs, [9:5]=rt, [4:0]=rd
- id_ex_pc_plus_4  in  32  PC+4 of the instruction
- id_ex_sign_ext  in  32  sign-extended immediate; [5:0] is funct
- id_ex_rd1  in  32  rs register value
- id_ex_rd2  in  32  rt register value
- id_ex_wb  in  2  [1]=RegWrite, [0]=MemtoReg
- id_ex_mem  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- id_ex_ex  in  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
- flush  in  1  branch-taken squash from MEM
- mem_wb_reg_write  in  1  MEM/WB RegWrite, for forwarding
- mem_wb_rd  in  5  MEM/WB destination register
- mem_wb_data  in  32  MEM/WB writeback value
- ex_stall  out  1  hold the ID/EX register and earlier stages
- ex_mem_wb  out  2  registered WB control
- ex_mem_mem  out  3  registered MEM control
- ex_mem_alu_result  out  32  registered ALU result
- ex_mem_write_data  out  32  registered store data (forwarded rt)
- ex_mem_rd  out  5  registered destination register
- ex_mem_zero  out  1  registered ALU zero flag
- ex_mem_branch_target  out  32  registered pc_plus_4 + (sign_ext << 2), mod 2^32

Behaviour:
- Reset:
  - startin=1 at a clock edge clears every registered output to 0.
  - Multiplier FSM returns to IDLE and its step counter clears to 0.
  - startin has priority over flush and the multiplier.
- Forwarding (combinational, operand A uses rs; B uses rt before the ALUSrc mux):
  - Priority 1: EX/MEM, when ex_mem_wb[1]=1, ex_mem_rd!=0 and ex_mem_rd==rs/rt.
  - Priority 2: MEM/WB, when mem_wb_reg_write=1, mem_wb_rd!=0 and mem_wb_rd==rs/rt.
  - Otherwise the id_ex register value.
- ALU B input: ALUSrc ? id_ex_sign_ext : forwarded B.
- Store data: always the forwarded B.
- Destination: RegDst ? rd : rt.
- ALUOp decode:
  - 00: add
  - 01: sub
  - 11: bitwise or
  - 10: decode by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0), 0x18 mul (low 32 bits, multi-cycle), any other funct gives 0.
- Arithmetic: add/sub wrap modulo 2^32 with no overflow flag; zero = (result==0).
- Multiplier FSM, states IDLE, MUL, DONE:
  - IDLE with a mul decoded: ex_stall=1 combinationally. At the edge, capture forwarded A and B, clear the accumulator and counter, go to MUL. The EX/MEM register loads a bubble (wb=0, mem=0, data=0).
  - MUL: one shift-add step per cycle; ex_stall=1; EX/MEM loads a bubble each cycle. After the 32nd step, go to DONE.
  - DONE: ex_stall=0. EX/MEM loads the product with the instruction's real WB/MEM/rd; go to IDLE.
  - Totals: ID/EX is held for 33 cycles and the result appears in EX/MEM 34 edges after the mul is first presented.
  - ex_stall = (IDLE and mul decoded) or MUL.
- Flush:
  - EX/MEM loads a bubble (all outputs 0) regardless of state.
  - If the FSM is in MUL or DONE, it aborts to IDLE and ex_stall drops in the next cycle.
  - If flush coincides with a mul decode in IDLE, the mul is not started.
- Non-mul instructions: single-cycle. EX/MEM loads the result at the next edge, ex_stall=0.

Decomposition:
- Shared package pipe_pkg holds:
  - ALUOp encodings and funct constants (ADD, SUB, AND, OR, SLT, MUL).
  - Control bit-index constants for WB, MEM and EX.
  - Field offsets for rs, rt and rd.
- One natural sub-module, alu_mul_seq: the iterative multiplier with its FSM and counter. Handshake: start in, abort in, busy out, done out, product out.

Test Plan:
- Reset:
  - Stimulus: drive nonzero inputs with startin=1 for 2 cycles.
  - Response: all ex_mem_* outputs are 0 and ex_stall=0.
- R-type add:
  - Stimulus: rd1=0x12345678, rd2=0x87654321, ALUOp=10, funct=0x20, RegDst=1, rd=3.
  - Response: next edge gives alu_result=0x99999999, rd=3, wb=10.
- Forwarding priority:
  - Stimulus: previous instruction wrote rd=5 with result 0x11111111; MEM/WB rd=5 carries data 0x22222222; next instruction uses rs=5.
  - Response: operand A is 0x11111111.
  - Also: with rd=0 on both paths, no forwarding occurs.
- Branch:
  - Stimulus: ALUOp=01, rd1=rd2=0x9ABCDEF0, pc_plus_4=0x10, sign_ext=0x20.
  - Response: zero=1 and branch_target=0x90.
- Multiply:
  - Stimulus: 0x00000007 × 0xFFFFFFFF, funct 0x18.
  - Response: ex_stall=1 for 33 cycles, EX/MEM holds bubbles meanwhile, then alu_result=0xFFFFFFF9 with real controls.
- Flush mid-multiply:
  - Stimulus: assert flush at step 10 of the multiply.
  - Response: bubble in EX/MEM, FSM back to IDLE, ex_stall=0 in the following cycle, no product written.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU op/funct codes,
// control bit positions and instruction field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  localparam int EX_REG_DST   = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_ALU_SRC   = 0;

  localparam int RS_LSB = 10;
  localparam int RT_LSB = 5;
  localparam int RD_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one step per cycle,
// low DATA_W bits of the product only.
module alu_mul_seq
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              startin,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W - 1);

  mul_state_e        state;
  mul_state_e        state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] acc;
  logic              launch;
  logic              stepping;

  assign launch   = (state == ST_IDLE) && start && !abort;
  assign stepping = (state == ST_MUL) && !abort;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (launch) state_nx = ST_MUL;
      ST_MUL: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (cnt == LAST)
          state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (startin)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (startin) begin
      cnt    <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
    end else if (launch) begin
      cnt    <= '0;
      acc    <= '0;
      mplier <= a;
      mcand  <= b;
    end else if (stepping) begin
      if (mplier[0])
        acc <= acc + mcand;
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign busy    = (state == ST_MUL);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, ALU, sequential
// multiplier and the EX/MEM pipeline register.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic               clock,
  input  logic               startin,
  input  logic [3*REG_W-1:0] id_ex_instr,
  input  logic [DATA_W-1:0]  id_ex_pc_plus_4,
  input  logic [DATA_W-1:0]  id_ex_sign_ext,
  input  logic [DATA_W-1:0]  id_ex_rd1,
  input  logic [DATA_W-1:0]  id_ex_rd2,
  input  logic [1:0]         id_ex_wb,
  input  logic [2:0]         id_ex_mem,
  input  logic [3:0]         id_ex_ex,
  input  logic               flush,
  input  logic               mem_wb_reg_write,
  input  logic [REG_W-1:0]   mem_wb_rd,
  input  logic [DATA_W-1:0]  mem_wb_data,
  output logic               ex_stall,
  output logic [1:0]         ex_mem_wb,
  output logic [2:0]         ex_mem_mem,
  output logic [DATA_W-1:0]  ex_mem_alu_result,
  output logic [DATA_W-1:0]  ex_mem_write_data,
  output logic [REG_W-1:0]   ex_mem_rd,
  output logic               ex_mem_zero,
  output logic [DATA_W-1:0]  ex_mem_branch_target
);

  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  dest;
  logic [5:0]        funct;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] product;
  logic              slt;
  logic              mul_dec;
  logic              mul_busy;
  logic              mul_done;
  logic              em_hit_a;
  logic              em_hit_b;
  logic              mw_hit_a;
  logic              mw_hit_b;

  assign rs     = id_ex_instr[RS_LSB +: REG_W];
  assign rt     = id_ex_instr[RT_LSB +: REG_W];
  assign rd     = id_ex_instr[RD_LSB +: REG_W];
  assign funct  = id_ex_sign_ext[5:0];
  assign alu_op = alu_op_e'(
    id_ex_ex[EX_ALU_OP_HI:EX_ALU_OP_LO]);

  assign em_hit_a = ex_mem_wb[WB_REG_WRITE]
    && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign em_hit_b = ex_mem_wb[WB_REG_WRITE]
    && (ex_mem_rd != '0) && (ex_mem_rd == rt);
  assign mw_hit_a = mem_wb_reg_write
    && (mem_wb_rd != '0) && (mem_wb_rd == rs);
  assign mw_hit_b = mem_wb_reg_write
    && (mem_wb_rd != '0) && (mem_wb_rd == rt);

  // Younger result in EX/MEM wins over MEM/WB
  always_comb begin
    fwd_a = id_ex_rd1;
    fwd_b = id_ex_rd2;
    if (em_hit_a)
      fwd_a = ex_mem_alu_result;
    else if (mw_hit_a)
      fwd_a = mem_wb_data;
    if (em_hit_b)
      fwd_b = ex_mem_alu_result;
    else if (mw_hit_b)
      fwd_b = mem_wb_data;
  end

  assign op_b = id_ex_ex[EX_ALU_SRC]
    ? id_ex_sign_ext : fwd_b;
  assign slt  = $signed(fwd_a) < $signed(op_b);
  assign dest = id_ex_ex[EX_REG_DST] ? rd : rt;
  assign target = id_ex_pc_plus_4
    + {id_ex_sign_ext[DATA_W-3:0], 2'b00};

  assign mul_dec = (alu_op == ALU_FUNCT)
    && (funct == F_MUL);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD: result = fwd_a + op_b;
      ALU_SUB: result = fwd_a - op_b;
      ALU_OR:  result = fwd_a | op_b;
      ALU_FUNCT: begin
        case (funct)
          F_ADD:   result = fwd_a + op_b;
          F_SUB:   result = fwd_a - op_b;
          F_AND:   result = fwd_a & op_b;
          F_OR:    result = fwd_a | op_b;
          F_SLT:   result = {{(DATA_W-1){1'b0}}, slt};
          F_MUL:   result = product;
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  alu_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clock   (clock),
    .startin (startin),
    .start   (mul_dec),
    .abort   (flush),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  assign ex_stall = mul_busy
    || (!mul_busy && !mul_done && mul_dec);

  always_ff @(posedge clock) begin
    if (startin || flush || ex_stall) begin
      ex_mem_wb            <= '0;
      ex_mem_mem           <= '0;
      ex_mem_alu_result    <= '0;
      ex_mem_write_data    <= '0;
      ex_mem_rd            <= '0;
      ex_mem_zero          <= 1'b0;
      ex_mem_branch_target <= '0;
    end else begin
      ex_mem_wb            <= id_ex_wb;
      ex_mem_mem           <= id_ex_mem;
      ex_mem_alu_result    <= result;
      ex_mem_write_data    <= fwd_b;
      ex_mem_rd            <= dest;
      ex_mem_zero          <= (result == '0);
      ex_mem_branch_target <= target;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage.
// Expected values are hand computed.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        startin;
  logic [14:0] id_ex_instr;
  logic [31:0] id_ex_pc_plus_4;
  logic [31:0] id_ex_sign_ext;
  logic [31:0] id_ex_rd1;
  logic [31:0] id_ex_rd2;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_mem;
  logic [3:0]  id_ex_ex;
  logic        flush;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        ex_stall;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_mem;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_write_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_zero;
  logic [31:0] ex_mem_branch_target;

  int total = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ex_mem_stage dut (
    .clock                (clock),
    .startin              (startin),
    .id_ex_instr          (id_ex_instr),
    .id_ex_pc_plus_4      (id_ex_pc_plus_4),
    .id_ex_sign_ext       (id_ex_sign_ext),
    .id_ex_rd1            (id_ex_rd1),
    .id_ex_rd2            (id_ex_rd2),
    .id_ex_wb             (id_ex_wb),
    .id_ex_mem            (id_ex_mem),
    .id_ex_ex             (id_ex_ex),
    .flush                (flush),
    .mem_wb_reg_write     (mem_wb_reg_write),
    .mem_wb_rd            (mem_wb_rd),
    .mem_wb_data          (mem_wb_data),
    .ex_stall             (ex_stall),
    .ex_mem_wb            (ex_mem_wb),
    .ex_mem_mem           (ex_mem_mem),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_write_data    (ex_mem_write_data),
    .ex_mem_rd            (ex_mem_rd),
    .ex_mem_zero          (ex_mem_zero),
    .ex_mem_branch_target (ex_mem_branch_target)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0]  rs,
                       input logic [4:0]  rt,
                       input logic [4:0]  rd,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] pc,
                       input logic [31:0] se,
                       input logic [1:0]  wb,
                       input logic [2:0]  mem,
                       input logic [3:0]  ex);
    id_ex_instr     = {rs, rt, rd};
    id_ex_rd1       = a;
    id_ex_rd2       = b;
    id_ex_pc_plus_4 = pc;
    id_ex_sign_ext  = se;
    id_ex_wb        = wb;
    id_ex_mem       = mem;
    id_ex_ex        = ex;
  endtask

  task automatic mw(input logic        w,
                    input logic [4:0]  r,
                    input logic [31:0] d);
    mem_wb_reg_write = w;
    mem_wb_rd        = r;
    mem_wb_data      = d;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 32'h0, 32'h0,
          32'h0, 32'h0, 2'b00, 3'b000, 4'b0000);
  endtask

  initial begin
    int n;
    int bad;

    // Reset with busy-looking inputs
    startin = 1'b1;
    flush   = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 32'h12345678,
          32'h87654321, 32'h100, 32'h20,
          2'b11, 3'b111, 4'b1100);
    mw(1'b1, 5'd1, 32'hCAFEBABE);
    step();
    step();
    chk("rst_wb", 32'(ex_mem_wb), 32'd0);
    chk("rst_mem", 32'(ex_mem_mem), 32'd0);
    chk("rst_alu", ex_mem_alu_result, 32'd0);
    chk("rst_wd", ex_mem_write_data, 32'd0);
    chk("rst_rd", 32'(ex_mem_rd), 32'd0);
    chk("rst_zero", 32'(ex_mem_zero), 32'd0);
    chk("rst_bt", ex_mem_branch_target, 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);

    // R-type add
    startin = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 32'h12345678,
          32'h87654321, 32'h100, 32'h20,
          2'b10, 3'b000, 4'b1100);
    mw(1'b0, 5'd0, 32'h0);
    #1;
    chk("add_stall", 32'(ex_stall), 32'd0);
    step();
    chk("add_alu", ex_mem_alu_result, 32'h99999999);
    chk("add_rd", 32'(ex_mem_rd), 32'd3);
    chk("add_wb", 32'(ex_mem_wb), 32'd2);
    chk("add_wd", ex_mem_write_data, 32'h87654321);
    chk("add_bt", ex_mem_branch_target, 32'h180);

    // Producer of r5 = 0x11111111
    drive(5'd6, 5'd7, 5'd5, 32'h11111111,
          32'h55, 32'h0, 32'h0,
          2'b10, 3'b000, 4'b1001);
    step();
    chk("prod_alu", ex_mem_alu_result, 32'h11111111);
    chk("prod_rd", 32'(ex_mem_rd), 32'd5);

    // Both paths hold r5: EX/MEM must win
    drive(5'd5, 5'd7, 5'd8, 32'hDEAD0000,
          32'h77, 32'h0, 32'h0,
          2'b10, 3'b000, 4'b1001);
    mw(1'b1, 5'd5, 32'h22222222);
    step();
    chk("fwd_em", ex_mem_alu_result, 32'h11111111);
    chk("fwd_em_rd", 32'(ex_mem_rd), 32'd8);

    // Only MEM/WB holds r5 now
    step();
    chk("fwd_mw", ex_mem_alu_result, 32'h22222222);

    // Writer to r0 with nonzero result
    drive(5'd9, 5'd7, 5'd0, 32'h33333333,
          32'h77, 32'h0, 32'h0,
          2'b10, 3'b000, 4'b1001);
    mw(1'b0, 5'd0, 32'h0);
    step();
    chk("r0_prod_rd", 32'(ex_mem_rd), 32'd0);

    // r0 on both paths never forwards
    drive(5'd0, 5'd0, 5'd4, 32'h0000ABCD,
          32'h100, 32'h0, 32'h0,
          2'b10, 3'b000, 4'b1000);
    mw(1'b1, 5'd0, 32'h22222222);
    step();
    chk("r0_alu", ex_mem_alu_result, 32'h0000ACCD);
    chk("r0_wd", ex_mem_write_data, 32'h100);

    // Branch compare
    drive(5'd10, 5'd11, 5'd12, 32'h9ABCDEF0,
          32'h9ABCDEF0, 32'h10, 32'h20,
          2'b00, 3'b100, 4'b0010);
    mw(1'b0, 5'd0, 32'h0);
    step();
    chk("br_zero", 32'(ex_mem_zero), 32'd1);
    chk("br_bt", ex_mem_branch_target, 32'h90);
    chk("br_alu", ex_mem_alu_result, 32'h0);
    chk("br_mem", 32'(ex_mem_mem), 32'd4);
    chk("br_rd", 32'(ex_mem_rd), 32'd11);

    // Signed slt: -1 < 1
    drive(5'd12, 5'd13, 5'd14, 32'hFFFFFFFF,
          32'h1, 32'h0, 32'h2A,
          2'b10, 3'b000, 4'b1100);
    step();
    chk("slt_alu", ex_mem_alu_result, 32'h1);
    chk("slt_zero", 32'(ex_mem_zero), 32'd0);

    // Unknown funct yields 0
    drive(5'd12, 5'd13, 5'd14, 32'hFFFFFFFF,
          32'h1, 32'h0, 32'h3F,
          2'b10, 3'b000, 4'b1100);
    step();
    chk("bad_f_alu", ex_mem_alu_result, 32'h0);
    chk("bad_f_zero", 32'(ex_mem_zero), 32'd1);

    // and
    drive(5'd20, 5'd21, 5'd22, 32'hFF00FF00,
          32'h0FF00FF0, 32'h0, 32'h24,
          2'b10, 3'b000, 4'b1100);
    step();
    chk("and_alu", ex_mem_alu_result, 32'h0F000F00);

    // sub wraps
    drive(5'd23, 5'd24, 5'd25, 32'h5,
          32'h7, 32'h0, 32'h22,
          2'b10, 3'b000, 4'b1100);
    step();
    chk("sub_alu", ex_mem_alu_result, 32'hFFFFFFFE);

    // Multiply 7 * 0xFFFFFFFF
    drive(5'd16, 5'd17, 5'd18, 32'h7,
          32'hFFFFFFFF, 32'h0, 32'h18,
          2'b10, 3'b000, 4'b1100);
    #1;
    chk("mul_stall0", 32'(ex_stall), 32'd1);
    n   = 0;
    bad = 0;
    while (ex_stall && n < 60) begin
      step();
      n++;
      if (ex_mem_wb !== 2'b00 ||
          ex_mem_alu_result !== 32'h0 ||
          ex_mem_rd !== 5'd0)
        bad++;
    end
    chk("mul_stall_cyc", 32'(n), 32'd33);
    chk("mul_bubbles", 32'(bad), 32'd0);
    chk("mul_done_stall", 32'(ex_stall), 32'd0);
    chk("mul_done_alu", ex_mem_alu_result, 32'h0);
    step();
    nop();
    chk("mul_alu", ex_mem_alu_result, 32'hFFFFFFF9);
    chk("mul_wb", 32'(ex_mem_wb), 32'd2);
    chk("mul_rd", 32'(ex_mem_rd), 32'd18);
    step();

    // Flush at step 10 of a multiply
    drive(5'd26, 5'd27, 5'd19, 32'h3,
          32'h5, 32'h0, 32'h18,
          2'b10, 3'b000, 4'b1100);
    repeat (10) step();
    chk("fl_busy", 32'(ex_stall), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    nop();
    #1;
    chk("fl_stall", 32'(ex_stall), 32'd0);
    chk("fl_wb", 32'(ex_mem_wb), 32'd0);
    chk("fl_alu", ex_mem_alu_result, 32'h0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_stall !== 1'b0 ||
          ex_mem_wb !== 2'b00 ||
          ex_mem_alu_result !== 32'h0)
        bad++;
    end
    chk("fl_no_prod", 32'(bad), 32'd0);

    // Flush on the decode cycle: mul never starts
    drive(5'd26, 5'd27, 5'd19, 32'h3,
          32'h5, 32'h0, 32'h18,
          2'b10, 3'b000, 4'b1100);
    flush = 1'b1;
    step();
    flush = 1'b0;
    nop();
    #1;
    chk("fl_idle_stall", 32'(ex_stall), 32'd0);
    chk("fl_idle_wb", 32'(ex_mem_wb), 32'd0);

    // Recovery: ALUOp or with immediate, RegDst=0
    drive(5'd28, 5'd29, 5'd30, 32'hF0F00000,
          32'h0, 32'h0, 32'h00000F0F,
          2'b11, 3'b010, 4'b0111);
    step();
    chk("or_alu", ex_mem_alu_result, 32'hF0F00F0F);
    chk("or_rd", 32'(ex_mem_rd), 32'd29);
    chk("or_mem", 32'(ex_mem_mem), 32'd2);
    chk("or_bt", ex_mem_branch_target, 32'h00003C3C);

    // Reset overrides flush and live inputs
    startin = 1'b1;
    flush   = 1'b1;
    step();
    chk("rst2_wb", 32'(ex_mem_wb), 32'd0);
    chk("rst2_alu", ex_mem_alu_result, 32'h0);

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
